complex_div_operand_packer: RTL and testbench

Upstream feeder for complex_div. Accepts a serial stream of WIDTH-bit IEEE-754 words in the order a, b, c, d (dividend re/im, divisor re/im). Assembles them into the NUM_OPERANDS-wide operand bundle and presents it on an fpnew-style valid/ready handshake matching complex_div's in_valid_i/in_ready_o/operands_i. Each bundle carries a sequence tag and a divide-by-zero flag.

---
 rtl/complex_div_operand_packer.sv | 121 ++++++++++++
 tb/tb_complex_div_operand_packer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_div_operand_packer.sv
// Serial-to-parallel operand packer feeding complex_div: collects a, b, c, d words into one
// bundle and hands it off on a valid/ready port together with a sequence tag and a /0 flag.
module complex_div_operand_packer #(
  parameter int unsigned NUM_OPERANDS = 4,
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned TAG_WIDTH    = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            word_valid_i,
  output logic                            word_ready_o,
  input  logic [WIDTH-1:0]                word_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [NUM_OPERANDS*WIDTH-1:0]   operands_o,
  output logic [TAG_WIDTH-1:0]            tag_o,
  output logic                            div_by_zero_o,
  output logic                            busy_o
);

  localparam int unsigned IdxW     = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam int unsigned NumSlots = (NUM_OPERANDS > 1) ? NUM_OPERANDS - 1 : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OPERANDS - 1);

  logic [NumSlots-1:0][WIDTH-1:0]   slots_q, slots_d;
  logic [IdxW-1:0]                  idx_q, idx_d;
  logic [NUM_OPERANDS*WIDTH-1:0]    operands_q, operands_d;
  logic [TAG_WIDTH-1:0]             tag_q, tag_d;
  logic [TAG_WIDTH-1:0]             tag_cnt_q, tag_cnt_d;
  logic                             dbz_q, dbz_d;
  logic                             valid_q, valid_d;

  logic [NUM_OPERANDS*WIDTH-1:0]    bundle;
  logic                             bundle_dbz;
  logic                             last_word;
  logic                             accept;

  assign last_word = (idx_q == LastIdx);

  // Only the final word can stall; it needs the output register to be free or draining.
  assign word_ready_o = !rst_i && !flush_i && !(last_word && valid_q && !out_ready_i);
  assign accept       = word_valid_i && word_ready_o;

  always_comb begin
    bundle = '0;
    for (int k = 0; k < NUM_OPERANDS - 1; k++) begin
      bundle[k*WIDTH +: WIDTH] = slots_q[k];
    end
    bundle[(NUM_OPERANDS-1)*WIDTH +: WIDTH] = word_i;
  end

  // Divisor is zero when both magnitudes are zero; sign bits are ignored.
  if (NUM_OPERANDS >= 4) begin : g_dbz
    assign bundle_dbz = ~|bundle[2*WIDTH +: WIDTH-1] && ~|bundle[3*WIDTH +: WIDTH-1];
  end else begin : g_no_dbz
    assign bundle_dbz = 1'b0;
  end

  always_comb begin
    slots_d    = slots_q;
    idx_d      = idx_q;
    operands_d = operands_q;
    tag_d      = tag_q;
    tag_cnt_d  = tag_cnt_q;
    dbz_d      = dbz_q;
    valid_d    = valid_q;
    if (flush_i) begin
      idx_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (valid_q && out_ready_i) begin
        valid_d = 1'b0;
      end
      if (accept) begin
        if (last_word) begin
          idx_d      = '0;
          operands_d = bundle;
          tag_d      = tag_cnt_q;
          tag_cnt_d  = tag_cnt_q + TAG_WIDTH'(1);
          dbz_d      = bundle_dbz;
          valid_d    = 1'b1;
        end else begin
          for (int k = 0; k < NUM_OPERANDS - 1; k++) begin
            if (idx_q == IdxW'(k)) begin
              slots_d[k] = word_i;
            end
          end
          idx_d = idx_q + IdxW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slots_q    <= '0;
      idx_q      <= '0;
      operands_q <= '0;
      tag_q      <= '0;
      tag_cnt_q  <= '0;
      dbz_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      slots_q    <= slots_d;
      idx_q      <= idx_d;
      operands_q <= operands_d;
      tag_q      <= tag_d;
      tag_cnt_q  <= tag_cnt_d;
      dbz_q      <= dbz_d;
      valid_q    <= valid_d;
    end
  end

  assign out_valid_o   = valid_q;
  assign operands_o    = operands_q;
  assign tag_o         = tag_q;
  assign div_by_zero_o = dbz_q;
  assign busy_o        = (idx_q != '0) || valid_q;

endmodule

// File: tb/tb_complex_div_operand_packer.sv
// Directed bench for complex_div_operand_packer with a bundle scoreboard checked on handshake.
module tb_complex_div_operand_packer;

  localparam int N = 4;
  localparam int W = 64;
  localparam int T = 4;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               flush_i;
  logic               word_valid_i;
  logic               word_ready_o;
  logic [W-1:0]       word_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [N*W-1:0]     operands_o;
  logic [T-1:0]       tag_o;
  logic               div_by_zero_o;
  logic               busy_o;

  complex_div_operand_packer #(
    .NUM_OPERANDS (N),
    .WIDTH        (W),
    .TAG_WIDTH    (T)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .word_valid_i  (word_valid_i),
    .word_ready_o  (word_ready_o),
    .word_i        (word_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .operands_o    (operands_o),
    .tag_o         (tag_o),
    .div_by_zero_o (div_by_zero_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N*W-1:0] ops;
    logic [T-1:0]   tag;
    logic           dbz;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] m_words[N];
  int           m_idx = 0;
  logic [T-1:0] m_tag = '0;

  task automatic chk(input string name, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_idx = 0;
    m_tag = '0;
  endtask

  // Presents one word and waits (bounded) for it to be taken; leaves word_valid_i high.
  task automatic send_word(input logic [W-1:0] w);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    word_valid_i = 1'b1;
    word_i       = w;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_i);
      if (word_ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("word_accept", {255'b0, ok}, 256'd1);
    if (!ok) begin
      word_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1;
    m_words[m_idx] = w;
    m_idx++;
    if (m_idx == N) begin
      e.ops = '0;
      for (int k = 0; k < N; k++) e.ops[k*W +: W] = m_words[k];
      e.tag = m_tag;
      e.dbz = (m_words[2][W-2:0] == '0) && (m_words[3][W-2:0] == '0);
      sb.push_back(e);
      m_tag++;
      m_idx = 0;
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_i === 1'b0 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_bundle", 256'd1, 256'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_operands", operands_o, e.ops);
        chk("sb_tag", {252'b0, tag_o}, {252'b0, e.tag});
        chk("sb_dbz", {255'b0, div_by_zero_o}, {255'b0, e.dbz});
      end
    end
  end

  initial begin
    logic [N*W-1:0] b1;
    logic [T-1:0]   exp_tag;
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    word_valid_i = 1'b0;
    word_i       = '0;
    out_ready_i  = 1'b1;
    #1;
    chk("rst_ready", {255'b0, word_ready_o}, 256'd0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", {255'b0, out_valid_o}, 256'd0);
    chk("rst_operands", operands_o, '0);
    chk("rst_tag", {252'b0, tag_o}, 256'd0);
    chk("rst_busy", {255'b0, busy_o}, 256'd0);
    rst_i = 1'b0;
    model_reset();

    // 1: single bundle, valid for exactly one cycle
    send_word(64'h401c000000000000);
    send_word(64'h4000000000000000);
    send_word(64'h3ff0000000000000);
    send_word(64'h4000000000000000);
    word_valid_i = 1'b0;
    chk("t1_valid_rise", {255'b0, out_valid_o}, 256'd1);
    chk("t1_operands", operands_o,
        {64'h4000000000000000, 64'h3ff0000000000000, 64'h4000000000000000, 64'h401c000000000000});
    chk("t1_tag", {252'b0, tag_o}, 256'd0);
    @(posedge clk_i);
    #1;
    chk("t1_valid_fall", {255'b0, out_valid_o}, 256'd0);
    chk("t1_busy", {255'b0, busy_o}, 256'd0);

    // 2: backpressure, last word of the second bundle stalls
    out_ready_i = 1'b0;
    send_word(64'h1111);
    send_word(64'h2222);
    send_word(64'h3333);
    send_word(64'h4444);
    b1 = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
    send_word(64'h5555);
    send_word(64'h6666);
    send_word(64'h7777);
    word_i = 64'h8888;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("t2_stall_ready", {255'b0, word_ready_o}, 256'd0);
      chk("t2_hold_operands", operands_o, b1);
      chk("t2_hold_valid", {255'b0, out_valid_o}, 256'd1);
    end
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;
    send_word(64'h8888);
    word_valid_i = 1'b0;
    chk("t2_reload_valid", {255'b0, out_valid_o}, 256'd1);
    chk("t2_b2_operands", operands_o, {64'h8888, 64'h7777, 64'h6666, 64'h5555});
    @(posedge clk_i);
    #1;
    chk("t2_drained", {255'b0, out_valid_o}, 256'd0);

    // 3: zero divisor (sign ignored), then a tiny nonzero divisor
    send_word(64'h3ff0000000000000);
    send_word(64'h0);
    send_word(64'h8000000000000000);
    send_word(64'h0000000000000000);
    word_valid_i = 1'b0;
    chk("t3_dbz_set", {255'b0, div_by_zero_o}, 256'd1);
    send_word(64'h0);
    send_word(64'h0);
    send_word(64'h0);
    send_word(64'h0000000000000001);
    word_valid_i = 1'b0;
    chk("t3_dbz_clear", {255'b0, div_by_zero_o}, 256'd0);
    @(posedge clk_i);
    #1;

    // 4: flush after two words
    send_word(64'hdead0001);
    send_word(64'hdead0002);
    flush_i = 1'b1;
    word_i  = 64'hdead0003;
    @(negedge clk_i);
    chk("t4_flush_ready", {255'b0, word_ready_o}, 256'd0);
    @(posedge clk_i);
    #1;
    flush_i      = 1'b0;
    word_valid_i = 1'b0;
    m_idx        = 0;
    chk("t4_busy_after", {255'b0, busy_o}, 256'd0);
    send_word(64'ha1);
    send_word(64'ha2);
    send_word(64'ha3);
    send_word(64'ha4);
    word_valid_i = 1'b0;
    chk("t4_post_flush", operands_o, {64'ha4, 64'ha3, 64'ha2, 64'ha1});
    @(posedge clk_i);
    #1;

    // 5: tag wrap over 17 back-to-back bundles from reset
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    model_reset();
    for (int b = 0; b < 17; b++) begin
      for (int k = 0; k < N; k++) send_word({$urandom(), $urandom()});
      exp_tag = T'(b % 16);
      chk("t5_tag", {252'b0, tag_o}, {252'b0, exp_tag});
    end
    word_valid_i = 1'b0;
    @(posedge clk_i);
    #1;

    // 6: async reset with a pending bundle and three partial words
    out_ready_i = 1'b0;
    for (int k = 0; k < N + 3; k++) send_word(64'hf00 + 64'(k));
    word_valid_i = 1'b0;
    #3;
    rst_i = 1'b1;
    #1;
    chk("t6_valid", {255'b0, out_valid_o}, 256'd0);
    chk("t6_operands", operands_o, '0);
    chk("t6_tag", {252'b0, tag_o}, 256'd0);
    chk("t6_busy", {255'b0, busy_o}, 256'd0);
    chk("t6_ready", {255'b0, word_ready_o}, 256'd0);
    model_reset();
    @(posedge clk_i);
    #2;
    rst_i       = 1'b0;
    out_ready_i = 1'b1;
    send_word(64'hb1);
    send_word(64'hb2);
    send_word(64'hb3);
    send_word(64'hb4);
    word_valid_i = 1'b0;
    chk("t6_new_valid", {255'b0, out_valid_o}, 256'd1);
    chk("t6_new_tag", {252'b0, tag_o}, 256'd0);
    chk("t6_new_operands", operands_o, {64'hb4, 64'hb3, 64'hb2, 64'hb1});
    @(posedge clk_i);
    #1;
    repeat (2) @(posedge clk_i);
    chk("sb_empty", 256'(sb.size()), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
